// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled Johnson counter word into one-hot and binary phase,
// tracks lock onto the legal sequence, and counts completed cycles while locked.
module johnson_phase_decoder #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int CYC_W    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              q_in,
   input  logic                          clr_err,
   output logic [2*WIDTH-1:0]            phase,
   output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
   output logic                          locked,
   output logic                          seq_err,
   output logic                          err_sticky,
   output logic                          wrap,
   output logic [CYC_W-1:0]              cycle_cnt
);

   localparam int N  = 2 * WIDTH;
   localparam int IW = $clog2(N);
   localparam int RW = $clog2(LOCK_CNT + 1);
   localparam logic [WIDTH-1:0] ONES     = '1;
   localparam logic [N-1:0]     ONE_HOT0 = N'(1);

   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

   state_t          state;
   logic [IW-1:0]   prev_idx;
   logic [RW-1:0]   run_cnt;

   int              pop_cnt;
   int              idx_int;
   logic [WIDTH-1:0] exp_code;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   next_idx;
   logic            legal;
   logic            good_step;
   logic            err_hit;

   // Index from popcount, then legality by regenerating the table entry for that index.
   always_comb begin
      pop_cnt = 0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_cnt = pop_cnt + int'(q_in[i]);
      end
      if (q_in == '0) begin
         idx_int = 0;
      end else if (q_in[0]) begin
         idx_int = pop_cnt;
      end else begin
         idx_int = N - pop_cnt;
      end
      if (idx_int <= WIDTH) begin
         exp_code = ~(ONES << idx_int);
      end else begin
         exp_code = ONES << (idx_int - WIDTH);
      end
      legal = (q_in == exp_code);
      idx   = IW'(idx_int);
   end

   assign next_idx  = (prev_idx == IW'(N - 1)) ? '0 : prev_idx + 1'b1;
   assign good_step = legal && (idx == next_idx);
   assign err_hit   = in_valid && (state == LOCKED) && !good_step;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= UNLOCKED;
         prev_idx   <= '0;
         run_cnt    <= '0;
         phase      <= '0;
         phase_idx  <= '0;
         locked     <= 1'b0;
         seq_err    <= 1'b0;
         err_sticky <= 1'b0;
         wrap       <= 1'b0;
         cycle_cnt  <= '0;
      end else begin
         seq_err <= err_hit;
         wrap    <= 1'b0;
         // Setting wins over clearing when both land in the same cycle.
         if (err_hit) begin
            err_sticky <= 1'b1;
         end else if (clr_err) begin
            err_sticky <= 1'b0;
         end
         if (in_valid) begin
            if (legal) begin
               phase     <= ONE_HOT0 << idx;
               phase_idx <= idx;
               prev_idx  <= idx;
            end else begin
               phase <= '0;
            end
            case (state)
               UNLOCKED: begin
                  if (legal) begin
                     run_cnt <= '0;
                     state   <= ACQUIRE;
                  end
               end
               ACQUIRE: begin
                  if (!legal) begin
                     state <= UNLOCKED;
                  end else if (good_step) begin
                     if (int'(run_cnt) + 1 == LOCK_CNT) begin
                        run_cnt <= '0;
                        state   <= LOCKED;
                        locked  <= 1'b1;
                     end else begin
                        run_cnt <= run_cnt + 1'b1;
                     end
                  end else begin
                     run_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!legal) begin
                     state  <= UNLOCKED;
                     locked <= 1'b0;
                  end else if (good_step) begin
                     if (prev_idx == IW'(N - 1)) begin
                        wrap      <= 1'b1;
                        cycle_cnt <= cycle_cnt + 1'b1;
                     end
                  end else begin
                     run_cnt <= '0;
                     state   <= ACQUIRE;
                     locked  <= 1'b0;
                  end
               end
               default: begin
                  state  <= UNLOCKED;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed plan steps then random traffic,
// checked against a table-lookup reference model.
module tb_johnson_phase_decoder;

   localparam int W  = 4;
   localparam int N  = 2 * W;
   localparam int LC = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  q_in;
   logic          clr_err;
   logic [N-1:0]  phase;
   logic [2:0]    phase_idx;
   logic          locked;
   logic          seq_err;
   logic          err_sticky;
   logic          wrap;
   logic [CW-1:0] cycle_cnt;

   johnson_phase_decoder #(.WIDTH(W), .LOCK_CNT(LC), .CYC_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .q_in(q_in), .clr_err(clr_err),
      .phase(phase), .phase_idx(phase_idx), .locked(locked), .seq_err(seq_err),
      .err_sticky(err_sticky), .wrap(wrap), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] codes [N];

   // Reference model: 0 unlocked, 1 acquiring, 2 locked.
   int            m_state, m_prev, m_run, m_idx;
   logic [N-1:0]  m_phase;
   bit            m_seq, m_sticky, m_wrap;
   logic [CW-1:0] m_cyc;

   function automatic int lookup(input logic [W-1:0] q);
      for (int k = 0; k < N; k++) begin
         if (codes[k] == q) return k;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_state = 0; m_prev = 0; m_run = 0; m_idx = 0;
      m_phase = '0; m_seq = 0; m_sticky = 0; m_wrap = 0; m_cyc = '0;
   endtask

   task automatic modelStep(input bit v, input logic [W-1:0] q, input bit c);
      int k;
      bit good;
      bit err;
      err = 0;
      m_wrap = 0;
      if (v) begin
         k = lookup(q);
         if (k >= 0) begin
            m_phase = N'(1) << k;
            m_idx = k;
         end else begin
            m_phase = '0;
         end
         good = (k >= 0) && (k == (m_prev + 1) % N);
         case (m_state)
            0: if (k >= 0) begin m_state = 1; m_run = 0; end
            1: begin
               if (k < 0) m_state = 0;
               else if (good) begin
                  m_run++;
                  if (m_run == LC) begin m_state = 2; m_run = 0; end
               end else m_run = 0;
            end
            default: begin
               if (k < 0) begin err = 1; m_state = 0; end
               else if (good) begin
                  if (m_prev == N - 1) begin m_wrap = 1; m_cyc = m_cyc + 1'b1; end
               end else begin err = 1; m_run = 0; m_state = 1; end
            end
         endcase
         if (k >= 0) m_prev = k;
      end
      m_seq = err;
      if (err) m_sticky = 1;
      else if (c) m_sticky = 0;
   endtask

   task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check1({tag, ".phase"},      32'(phase),      32'(m_phase));
      check1({tag, ".phase_idx"},  32'(phase_idx),  32'(m_idx));
      check1({tag, ".locked"},     32'(locked),     32'(m_state == 2));
      check1({tag, ".seq_err"},    32'(seq_err),    32'(m_seq));
      check1({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
      check1({tag, ".wrap"},       32'(wrap),       32'(m_wrap));
      check1({tag, ".cycle_cnt"},  32'(cycle_cnt),  32'(m_cyc));
   endtask

   task automatic applyStimulus(input bit v, input logic [W-1:0] q, input bit c, input string tag);
      in_valid = v;
      q_in     = q;
      clr_err  = c;
      @(posedge clk);
      modelStep(v, q, c);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      int cur;
      int r;
      bit c;
      logic [W-1:0] rq;

      for (int k = 0; k < N; k++) begin
         if (k <= W) codes[k] = W'((1 << k) - 1);
         else        codes[k] = W'(((1 << W) - 1) ^ ((1 << (k - W)) - 1));
      end
      $display("[TB] start");

      rst = 1'b0; in_valid = 1'b0; q_in = '0; clr_err = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      rst = 1'b1;

      for (int k = 0; k < 4; k++) applyStimulus(1, codes[k], 0, "acquire");
      check1("acquire.locked", 32'(locked), 32'd1);
      check1("acquire.idx", 32'(phase_idx), 32'd3);
      check1("acquire.phase", 32'(phase), 32'h08);

      for (int k = 4; k < N; k++) applyStimulus(1, codes[k], 0, "run");
      applyStimulus(1, codes[0], 0, "wrap");
      check1("wrap.pulse", 32'(wrap), 32'd1);
      check1("wrap.cycles", 32'(cycle_cnt), 32'd1);
      check1("wrap.phase", 32'(phase), 32'h01);
      applyStimulus(1, codes[1], 0, "after_wrap");
      check1("after_wrap.pulse", 32'(wrap), 32'd0);

      applyStimulus(1, 4'b0101, 0, "illegal");
      check1("illegal.seq_err", 32'(seq_err), 32'd1);
      check1("illegal.sticky", 32'(err_sticky), 32'd1);
      check1("illegal.phase", 32'(phase), 32'd0);
      applyStimulus(0, 4'b0000, 1, "clr_err");
      check1("clr_err.sticky", 32'(err_sticky), 32'd0);
      check1("clr_err.seq_err", 32'(seq_err), 32'd0);

      applyStimulus(1, codes[7], 0, "relock");
      for (int k = 0; k < 3; k++) applyStimulus(1, codes[k], 0, "relock");
      check1("relock.locked", 32'(locked), 32'd1);
      applyStimulus(1, 4'b1111, 0, "skip");
      check1("skip.seq_err", 32'(seq_err), 32'd1);
      check1("skip.idx", 32'(phase_idx), 32'd4);
      check1("skip.locked", 32'(locked), 32'd0);
      for (int k = 5; k < N; k++) applyStimulus(1, codes[k], 0, "skip_relock");
      check1("skip_relock.locked", 32'(locked), 32'd1);

      for (int i = 0; i < 5; i++) applyStimulus(0, W'($urandom), 0, "stall");
      applyStimulus(1, codes[0], 0, "resume");
      check1("resume.locked", 32'(locked), 32'd1);

      applyStimulus(1, 4'b1001, 1, "set_wins");
      check1("set_wins.sticky", 32'(err_sticky), 32'd1);

      applyStimulus(1, codes[7], 0, "prereset");
      for (int k = 0; k < 3; k++) applyStimulus(1, codes[k], 0, "prereset");
      #2 rst = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset");
      check1("async_reset.locked", 32'(locked), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(0, W'($urandom), 0, "post_reset");

      cur = 0;
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         c = ($urandom_range(0, 9) == 0);
         if (r < 72) begin
            cur = (cur + 1) % N;
            applyStimulus(1, codes[cur], c, "rand_step");
         end else if (r < 80) begin
            applyStimulus(0, W'($urandom), c, "rand_idle");
         end else if (r < 88) begin
            cur = int'($urandom_range(0, N - 1));
            applyStimulus(1, codes[cur], c, "rand_jump");
         end else begin
            do rq = W'($urandom); while (lookup(rq) >= 0);
            applyStimulus(1, rq, c, "rand_illegal");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the 4-bit Johnson counter. Samples the counter word, decodes it to a one-hot phase and a binary phase index, and checks that the input follows the legal Johnson sequence.
- Declares lock after a run of correct steps, flags sequence errors, and counts completed cycles.
- Sits between the Johnson counter and phase-driven logic (strobes, mux selects).

Parameters:
WIDTH, 4, Johnson counter width; sequence length is 2*WIDTH.
LOCK_CNT, 3, consecutive correct steps required to enter LOCKED (>=1).
CYC_W, 16, width of the completed-cycle counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  q_in is sampled on this edge.
q_in  input  WIDTH  Johnson counter word.
clr_err  input  1  synchronous clear of err_sticky.
phase  output  2*WIDTH  one-hot decoded phase; all zero when the last sample was illegal.
phase_idx  output  $clog2(2*WIDTH)  binary phase index (3 bits at default).
locked  output  1  high while the state is LOCKED.
seq_err  output  1  one-cycle pulse on a sequence violation while LOCKED.
err_sticky  output  1  set by seq_err; cleared by clr_err.
wrap  output  1  one-cycle pulse when index 2W-1 -> 0 while LOCKED.
cycle_cnt  output  CYC_W  completed cycles while LOCKED; wraps modulo 2^CYC_W.

Behaviour:
- Sequence definition (LSB shift-in, W=4): 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
- Index mapping:
  - q==0 -> idx 0.
  - q[0]==1 -> idx = popcount(q).
  - otherwise -> idx = 2W - popcount(q).
- Legality: a code is legal iff it equals the table entry for its computed index. Any other code (e.g. 0101, 1001) is illegal.
- Correct step: idx == (prev_idx+1) mod 2W. Hold (same idx) is a wrong step.
- Timing: all outputs are registered. A sample taken at edge N is reflected on the outputs after edge N (latency 1). Pulses last exactly one cycle.
- Reset (rst=0, async): state=UNLOCKED, prev_idx=0, run_cnt=0, and every output is 0.
- in_valid=0: state, counters, phase and phase_idx hold; seq_err=0 and wrap=0.
- On every valid sample:
  - Legal -> phase_idx=idx, phase=1<<idx.
  - Illegal -> phase=0, phase_idx holds.
- FSM, evaluated on valid samples only:
  - UNLOCKED:
    - legal -> prev_idx=idx, run_cnt=0, go to ACQUIRE.
    - illegal -> stay.
  - ACQUIRE:
    - legal and correct step -> run_cnt+1; if run_cnt+1==LOCK_CNT go to LOCKED (run_cnt=0).
    - legal and wrong step -> prev_idx=idx, run_cnt=0, stay.
    - illegal -> go to UNLOCKED.
    - seq_err is never raised in ACQUIRE.
  - LOCKED:
    - correct step -> stay; wrap=1 and cycle_cnt+1 when prev_idx==2W-1.
    - legal and wrong step -> seq_err=1, err_sticky=1, prev_idx=idx, run_cnt=0, go to ACQUIRE.
    - illegal -> seq_err=1, err_sticky=1, go to UNLOCKED.
  - prev_idx updates to idx on every legal sample.
- clr_err and seq_err in the same cycle: set wins, err_sticky=1.
- cycle_cnt is not cleared on loss of lock; only reset clears it.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for a clock edge. After release, the first valid legal sample re-enters ACQUIRE.

Test Plan:
- Reset: drive rst=0 mid-run with locked=1 -> all outputs 0 asynchronously. Release, hold in_valid=0 -> outputs stay 0.
- Acquire: valid samples 0000,0001,0011,0111 -> after the 4th edge, locked=1, phase_idx=3, phase=8'b0000_1000, seq_err=0.
- Wrap: continue 1111..1000,0000 -> wrap=1 for exactly one cycle on the 0000 sample; cycle_cnt=1, phase=8'b0000_0001.
- Illegal code: while locked, inject 0101 -> seq_err pulses 1 cycle, err_sticky=1, locked=0, phase=0. Pulse clr_err -> err_sticky=0.
- Skipped step: locked at 0011, feed 1111 -> seq_err=1, state ACQUIRE, phase_idx=4. Feed 1110,1100,1000 -> locked=1 after the 3rd sample.
- Stall: in_valid=0 for 5 cycles mid-sequence -> outputs hold, no seq_err. Resume with the next code -> locked stays 1.
